// File: rtl/cipher_rx_pkg.sv
// Shared defaults and FSM state type for the cipher stream receiver.
package cipher_rx_pkg;

    localparam int unsigned MSG_SIZE_DEFAULT   = 512;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        RECV
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous 8-bit FIFO; a push while full is accepted only when a pop frees a slot the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_stream_rx.sv
// Deserializes a framed ciphertext bit stream MSB-first into bytes, buffering them in a FIFO
// and flagging length errors, aborted frames and FIFO overflow.
module cipher_stream_rx
    import cipher_rx_pkg::*;
#(
    parameter int unsigned MSG_SIZE   = MSG_SIZE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        serial_in,
    input  logic                        serial_start,
    input  logic                        serial_end,
    output logic [7:0]                  byte_out,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(MSG_SIZE):0]   bit_count
);

    localparam int unsigned   CW      = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] MSG_LEN = CW'(MSG_SIZE);

    rx_state_t     state;
    logic [6:0]    shift_reg;
    logic [CW-1:0] next_count;
    logic          push_byte;
    logic [7:0]    push_data;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign next_count = bit_count + CW'(1);
    assign push_data  = {shift_reg, serial_in};
    assign pop        = byte_valid && byte_ready;
    assign byte_valid = !fifo_empty;

    // A byte completes only on a normal in-frame sample: restarts and over-length bits never push.
    always_comb begin
        push_byte = 1'b0;
        if (ena && (state == RECV) && !serial_start && (bit_count != MSG_LEN)
                && (next_count[2:0] == 3'd0)) begin
            push_byte = 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_byte),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (byte_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (ena) begin
                if (serial_start) begin
                    // Fresh capture; an abort from RECV keeps the error visible for the new frame.
                    shift_reg <= {6'b0, serial_in};
                    bit_count <= CW'(1);
                    overflow  <= 1'b0;
                    frame_err <= (state == RECV) || serial_end;
                    if (serial_end) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end else if (state == RECV) begin
                    if (bit_count == MSG_LEN) begin
                        frame_err  <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        shift_reg <= {shift_reg[5:0], serial_in};
                        bit_count <= next_count;
                        if (serial_end) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            if (next_count != MSG_LEN) begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
            end
            if (push_byte && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cipher_stream_rx.sv
// Directed-vector bench for cipher_stream_rx with a 512-bit frame and 8-entry FIFO.
module tb_cipher_stream_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       serial_in;
    logic       serial_start;
    logic       serial_end;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;
    logic [9:0] bit_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    int         done_cnt = 0;

    cipher_stream_rx #(
        .MSG_SIZE   (512),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .serial_in    (serial_in),
        .serial_start (serial_start),
        .serial_end   (serial_end),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid && byte_ready) rx_q.push_back(byte_out);
        if (frame_done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic e, input logic s, input logic st, input logic en);
        @(posedge clk);
        #1;
        ena          = e;
        serial_in    = s;
        serial_start = st;
        serial_end   = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Byte k of a frame is pat + inc*k; start on bit 0, optional end on the last bit.
    task automatic send_bits(input int nbits, input int pat, input int inc,
                             input bit with_end, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < nbits; i++) begin
            b = 8'(pat + inc * (i / 8));
            drive(1'b1, b[7 - (i % 8)], i == 0, with_end && (i == nbits - 1));
            if (gaps) drive(1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b1);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (byte_valid && byte_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s drain: FIFO still non-empty after %0d cycles, required empty", name, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; serial_in = 1'b0; serial_start = 1'b0; serial_end = 1'b0;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({byte_valid, byte_out, frame_done, frame_err, overflow, bit_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b out=%h done=%b err=%b ovf=%b cnt=%0d, required all 0",
                     byte_valid, byte_out, frame_done, frame_err, overflow, bit_count);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_full_frame();
        int base = rx_q.size();
        int dbase = done_cnt;
        send_bits(512, 8'hA5, 0, 1'b1, 1'b0);
        wait_drain("full_frame");
        checks++;
        if (rx_q.size() - base !== 64) begin
            errors++; $display("FAIL full_frame count: got %0d required 64", rx_q.size() - base);
        end
        for (int k = 0; k < 64 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== 8'hA5) begin
                errors++; $display("FAIL full_frame byte %0d: got %h required a5", k, rx_q[base + k]);
            end
        end
        checks++;
        if (done_cnt - dbase !== 1) begin
            errors++; $display("FAIL full_frame done: got %0d pulses required 1", done_cnt - dbase);
        end
        checks++;
        if (frame_err !== 1'b0 || overflow !== 1'b0 || bit_count !== 10'd512) begin
            errors++; $display("FAIL full_frame flags: got err=%b ovf=%b cnt=%0d required 0 0 512",
                               frame_err, overflow, bit_count);
        end
    endtask

    task automatic test_short_frame();
        int base = rx_q.size();
        int dbase = done_cnt;
        send_bits(300, 8'h40, 3, 1'b1, 1'b0);
        wait_drain("short_frame");
        checks++;
        if (rx_q.size() - base !== 37) begin
            errors++; $display("FAIL short_frame count: got %0d required 37", rx_q.size() - base);
        end
        for (int k = 0; k < 37 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== 8'(8'h40 + 3 * k)) begin
                errors++; $display("FAIL short_frame byte %0d: got %h required %h",
                                   k, rx_q[base + k], 8'(8'h40 + 3 * k));
            end
        end
        checks++;
        if (done_cnt - dbase !== 1 || frame_err !== 1'b1 || bit_count !== 10'd300) begin
            errors++; $display("FAIL short_frame flags: got done=%0d err=%b cnt=%0d required 1 1 300",
                               done_cnt - dbase, frame_err, bit_count);
        end
    endtask

    task automatic test_one_bit_frame();
        int base = rx_q.size();
        int dbase = done_cnt;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);
        checks++;
        if (done_cnt - dbase !== 1 || frame_err !== 1'b1 || bit_count !== 10'd1
                || rx_q.size() !== base || byte_valid !== 1'b0) begin
            errors++; $display("FAIL one_bit_frame: got done=%0d err=%b cnt=%0d bytes=%0d required 1 1 1 0",
                               done_cnt - dbase, frame_err, bit_count, rx_q.size() - base);
        end
    endtask

    task automatic test_too_long();
        int base = rx_q.size();
        int dbase = done_cnt;
        send_bits(512, 8'h77, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain("too_long");
        checks++;
        if (rx_q.size() - base !== 64 || done_cnt - dbase !== 1 || frame_err !== 1'b1
                || bit_count !== 10'd512) begin
            errors++; $display("FAIL too_long: got bytes=%0d done=%0d err=%b cnt=%0d required 64 1 1 512",
                               rx_q.size() - base, done_cnt - dbase, frame_err, bit_count);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (bit_count !== 10'd512 || byte_valid !== 1'b0 || done_cnt - dbase !== 1) begin
            errors++; $display("FAIL too_long_idle: got cnt=%0d valid=%b done=%0d required 512 0 1",
                               bit_count, byte_valid, done_cnt - dbase);
        end
    endtask

    task automatic test_backpressure();
        int base;
        byte_ready = 1'b0;
        send_bits(512, 8'h10, 1, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (overflow !== 1'b1 || byte_valid !== 1'b1 || byte_out !== 8'h10 || frame_err !== 1'b0) begin
            errors++; $display("FAIL backpressure flags: got ovf=%b valid=%b head=%h err=%b required 1 1 10 0",
                               overflow, byte_valid, byte_out, frame_err);
        end
        base = rx_q.size();
        byte_ready = 1'b1;
        wait_drain("backpressure");
        checks++;
        if (rx_q.size() - base !== 8) begin
            errors++; $display("FAIL backpressure count: got %0d required 8", rx_q.size() - base);
        end
        for (int k = 0; k < 8 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== 8'(8'h10 + k)) begin
                errors++; $display("FAIL backpressure byte %0d: got %h required %h",
                                   k, rx_q[base + k], 8'(8'h10 + k));
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL backpressure sticky: got ovf=%b required 1", overflow);
        end
    endtask

    task automatic test_restart();
        int base = rx_q.size();
        send_bits(100, 8'h11, 0, 1'b0, 1'b0);
        send_bits(512, 8'h3C, 0, 1'b1, 1'b0);
        wait_drain("restart");
        checks++;
        if (rx_q.size() - base !== 76) begin
            errors++; $display("FAIL restart count: got %0d required 76", rx_q.size() - base);
        end
        for (int k = 0; k < 76 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== (k < 12 ? 8'h11 : 8'h3C)) begin
                errors++; $display("FAIL restart byte %0d: got %h required %h",
                                   k, rx_q[base + k], (k < 12 ? 8'h11 : 8'h3C));
            end
        end
        checks++;
        if (frame_err !== 1'b1 || bit_count !== 10'd512 || overflow !== 1'b0) begin
            errors++; $display("FAIL restart flags: got err=%b cnt=%0d ovf=%b required 1 512 0",
                               frame_err, bit_count, overflow);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        byte_ready = 1'b0;
        send_bits(200, 8'h99, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ena   = 1'b0;
        #1;
        checks++;
        if ({byte_valid, byte_out, frame_done, frame_err, overflow, bit_count} !== '0) begin
            errors++; $display("FAIL reset_mid: got valid=%b out=%h done=%b err=%b ovf=%b cnt=%0d required all 0",
                               byte_valid, byte_out, frame_done, frame_err, overflow, bit_count);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        byte_ready = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (bit_count !== 10'd0 || byte_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_start: got cnt=%0d valid=%b required 0 0", bit_count, byte_valid);
        end
        base = rx_q.size();
        send_bits(512, 8'h5A, 0, 1'b1, 1'b0);
        wait_drain("reset_clean");
        checks++;
        if (rx_q.size() - base !== 64 || frame_err !== 1'b0 || bit_count !== 10'd512) begin
            errors++; $display("FAIL reset_clean: got bytes=%0d err=%b cnt=%0d required 64 0 512",
                               rx_q.size() - base, frame_err, bit_count);
        end
        for (int k = 0; k < 64 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== 8'h5A) begin
                errors++; $display("FAIL reset_clean byte %0d: got %h required 5a", k, rx_q[base + k]);
            end
        end
    endtask

    task automatic test_ena_toggle();
        int base = rx_q.size();
        int dbase = done_cnt;
        send_bits(512, 8'hA5, 0, 1'b1, 1'b1);
        wait_drain("ena_toggle");
        checks++;
        if (rx_q.size() - base !== 64 || done_cnt - dbase !== 1 || frame_err !== 1'b0
                || bit_count !== 10'd512) begin
            errors++; $display("FAIL ena_toggle: got bytes=%0d done=%0d err=%b cnt=%0d required 64 1 0 512",
                               rx_q.size() - base, done_cnt - dbase, frame_err, bit_count);
        end
        for (int k = 0; k < 64 && base + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[base + k] !== 8'hA5) begin
                errors++; $display("FAIL ena_toggle byte %0d: got %h required a5", k, rx_q[base + k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_one_bit_frame();
        test_too_long();
        test_backpressure();
        test_restart();
        test_reset_midframe();
        test_ena_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
